// File: rtl/car_led_pkg.sv
// ---------------------------------------------------------------------------
// car_led_pkg : command codes and state enumeration shared with the light
//               controller, plus a saturating-decrement helper.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package car_led_pkg;

  localparam logic [3:0] c_OFF      = 4'b0000;
  localparam logic [3:0] c_STRAIGHT = 4'b0110;
  localparam logic [3:0] c_LEFT     = 4'b1000;
  localparam logic [3:0] c_RIGHT    = 4'b0001;
  localparam logic [3:0] c_HAZARD   = 4'b1111;

  typedef enum logic [3:0] {
    ST_OFF      = 4'b0000,
    ST_STRAIGHT = 4'b0110,
    ST_LEFT     = 4'b1000,
    ST_RIGHT    = 4'b0001,
    ST_HAZARD   = 4'b1111
  } car_state_e;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/car_cmd_gen_rise_det.sv
// ---------------------------------------------------------------------------
// rise_det : one-cycle pulse on a 0->1 change of a sampled level.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic r_prev;
  logic r_armed;

  // The first sample after reset only primes r_prev, so a level already
  // held high through reset never reads as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= d;
      r_armed <= 1'b1;
    end
  end

  assign pulse = d & ~r_prev & r_armed;

endmodule

`default_nettype wire

// File: rtl/car_cmd_gen.sv
// ---------------------------------------------------------------------------
// car_cmd_gen : turn / hazard / fault command generator for the light bar.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module car_cmd_gen
  import car_led_pkg::*;
#(
  parameter int TURN_SEC   = 8,
  parameter int FAULT_HOLD = 3
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       drive_en,
  input  logic       turn_l,
  input  logic       turn_r,
  input  logic       hazard_btn,
  input  logic       fault,
  output logic [3:0] sw_code,
  output logic [3:0] timer,
  output logic       hazard_on
);

  localparam logic [3:0] c_TURN_LOAD = 4'(TURN_SEC);
  localparam logic [3:0] c_HOLD_LOAD = 4'(FAULT_HOLD);

  logic [3:0] r_state;
  logic [3:0] r_turn;
  logic [3:0] r_hold;
  logic       r_hazard;
  logic       r_fault_q;
  logic       r_lock_l;
  logic       r_lock_r;

  logic       w_btn_rise;
  logic       w_haz_next;
  logic [3:0] w_hold_next;
  logic [3:0] w_turn_dec;
  logic [3:0] w_base;
  logic       w_req_l;
  logic       w_req_r;
  logic       w_lock_l_next;
  logic       w_lock_r_next;
  logic [3:0] w_state_next;
  logic [3:0] w_turn_next;

  rise_det u_btn_rise (
    .clk   (clk_1Hz),
    .rst   (rst),
    .d     (hazard_btn),
    .pulse (w_btn_rise)
  );

  always_comb begin
    w_haz_next    = r_hazard ^ w_btn_rise;
    w_hold_next   = fault ? 4'd0 : (r_fault_q ? c_HOLD_LOAD : sat_dec(r_hold));
    w_lock_l_next = r_lock_l & turn_l;
    w_lock_r_next = r_lock_r & turn_r;
    w_req_l       = turn_l & ~turn_r & ~r_lock_l;
    w_req_r       = turn_r & ~turn_l & ~r_lock_r;
    w_base        = drive_en ? c_STRAIGHT : c_OFF;
    w_turn_dec    = sat_dec(r_turn);
    w_state_next  = w_base;
    w_turn_next   = 4'd0;

    // Hazard sources win outright and leave the turn counter cleared, so
    // leaving HAZARD always re-enters a turn with a fresh load.
    if (fault | w_haz_next | (w_hold_next != 4'd0)) begin
      w_state_next = c_HAZARD;
    end else if (w_req_l) begin
      if (r_state != c_LEFT) begin
        w_state_next = c_LEFT;
        w_turn_next  = c_TURN_LOAD;
      end else if (w_turn_dec != 4'd0) begin
        w_state_next = c_LEFT;
        w_turn_next  = w_turn_dec;
      end else begin
        w_lock_l_next = 1'b1;
      end
    end else if (w_req_r) begin
      if (r_state != c_RIGHT) begin
        w_state_next = c_RIGHT;
        w_turn_next  = c_TURN_LOAD;
      end else if (w_turn_dec != 4'd0) begin
        w_state_next = c_RIGHT;
        w_turn_next  = w_turn_dec;
      end else begin
        w_lock_r_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      r_state   <= c_OFF;
      r_turn    <= 4'd0;
      r_hold    <= 4'd0;
      r_hazard  <= 1'b0;
      r_fault_q <= 1'b0;
      r_lock_l  <= 1'b0;
      r_lock_r  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_turn    <= w_turn_next;
      r_hold    <= w_hold_next;
      r_hazard  <= w_haz_next;
      r_fault_q <= fault;
      r_lock_l  <= w_lock_l_next;
      r_lock_r  <= w_lock_r_next;
    end
  end

  assign sw_code   = r_state;
  assign timer     = (r_hold != 4'd0) ? r_hold : r_turn;
  assign hazard_on = r_hazard;

endmodule

`default_nettype wire

// File: tb/tb_car_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_car_cmd_gen : scoreboard bench for car_cmd_gen with a behavioural model.
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_car_cmd_gen;

  localparam int TURN_SEC   = 8;
  localparam int FAULT_HOLD = 3;

  logic       clk_1Hz = 1'b0;
  logic       rst = 1'b1;
  logic       drive_en = 1'b0;
  logic       turn_l = 1'b0;
  logic       turn_r = 1'b0;
  logic       hazard_btn = 1'b0;
  logic       fault = 1'b0;
  logic [3:0] sw_code;
  logic [3:0] timer;
  logic       hazard_on;

  car_cmd_gen #(.TURN_SEC(TURN_SEC), .FAULT_HOLD(FAULT_HOLD)) dut (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .drive_en   (drive_en),
    .turn_l     (turn_l),
    .turn_r     (turn_r),
    .hazard_btn (hazard_btn),
    .fault      (fault),
    .sw_code    (sw_code),
    .timer      (timer),
    .hazard_on  (hazard_on)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int vectors     = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  // Reference model: mode 0 = base, 1 = left, 2 = right, 3 = hazard.
  int   m_mode, m_remain, m_hold;
  bit   m_latch, m_lock_l, m_lock_r, m_prev_btn, m_prev_fault, m_seen;
  logic [3:0] m_sw;

  task automatic model(input bit r, input bit de, input bit tl, input bit tr,
                       input bit hb, input bit f);
    bit want_l, want_r;
    if (!r) begin
      m_mode = 0; m_remain = 0; m_hold = 0; m_latch = 0;
      m_lock_l = 0; m_lock_r = 0; m_prev_btn = 0; m_prev_fault = 0; m_seen = 0;
      m_sw = 4'b0000;
      return;
    end
    if (m_seen && hb && !m_prev_btn) m_latch = !m_latch;
    m_prev_btn = hb;
    m_seen = 1;
    if (f) m_hold = 0;
    else if (m_prev_fault) m_hold = FAULT_HOLD;
    else if (m_hold > 0) m_hold = m_hold - 1;
    m_prev_fault = f;
    if (!tl) m_lock_l = 0;
    if (!tr) m_lock_r = 0;
    want_l = tl && !tr && !m_lock_l;
    want_r = tr && !tl && !m_lock_r;
    if (f || m_latch || m_hold > 0) begin
      m_mode = 3; m_remain = 0;
    end else if (m_mode == 1 && want_l) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) begin m_mode = 0; m_lock_l = 1; end
    end else if (want_l) begin
      m_mode = 1; m_remain = TURN_SEC;
    end else if (m_mode == 2 && want_r) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) begin m_mode = 0; m_lock_r = 1; end
    end else if (want_r) begin
      m_mode = 2; m_remain = TURN_SEC;
    end else begin
      m_mode = 0; m_remain = 0;
    end
    case (m_mode)
      1:       m_sw = 4'b1000;
      2:       m_sw = 4'b0001;
      3:       m_sw = 4'b1111;
      default: m_sw = de ? 4'b0110 : 4'b0000;
    endcase
  endtask

  task automatic step(input bit r, input bit de, input bit tl, input bit tr,
                      input bit hb, input bit f);
    int t;
    @(negedge clk_1Hz);
    rst = r; drive_en = de; turn_l = tl; turn_r = tr; hazard_btn = hb; fault = f;
    model(r, de, tl, tr, hb, f);
    t = (m_hold > 0) ? m_hold : m_remain;
    exp_q.push_back({m_sw, 4'(t), m_latch});
  endtask

  // Monitor: one output word per clock edge once stimulus is queued.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk_1Hz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({sw_code, timer, hazard_on} !== e) begin
          miscompares++;
          $display("FAIL cycle_out @%0t: got sw_code=%b timer=%0d hazard_on=%b, expected sw_code=%b timer=%0d hazard_on=%b",
                   $time, sw_code, timer, hazard_on, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    bit rde, rtl, rtr, rhb, rf, rr;
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({sw_code, timer, hazard_on} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_async: got sw_code=%b timer=%0d hazard_on=%b, expected 0000/0/0",
               sw_code, timer, hazard_on);
    end
    model(0, 0, 0, 0, 0, 0);

    repeat (2) step(0, 1, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0, 0);
    // Left timeout, lock, re-arm.
    repeat (12) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0, 0);
    // Direct left -> right switch at timer 5.
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 1, 0, 0);
    // Hazard toggled on and off while in RIGHT.
    step(1, 1, 0, 1, 1, 0);
    repeat (3) step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    repeat (3) step(1, 1, 0, 1, 0, 0);
    // Fault with hold, then re-pulse during hold.
    repeat (4) step(1, 1, 0, 0, 0, 1);
    repeat (5) step(1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0, 1);
    repeat (2) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    repeat (5) step(1, 1, 0, 0, 0, 0);
    // Both levers while parked.
    repeat (4) step(1, 0, 1, 1, 0, 0);
    // Reset mid-hazard with the button held through release.
    step(1, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    repeat (4) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    rde = 1; rtl = 0; rtr = 0; rhb = 0; rf = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) rde = ~rde;
      if ($urandom_range(9) == 0)  rtl = ~rtl;
      if ($urandom_range(9) == 0)  rtr = ~rtr;
      if ($urandom_range(11) == 0) rhb = ~rhb;
      if (rf) rf = ($urandom_range(3) != 0);
      else    rf = ($urandom_range(39) == 0);
      rr = ($urandom_range(199) != 0);
      step(rr, rde, rtl, rtr, rhb, rf);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk_1Hz);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/car_cmd_gen.md
CAR_CMD_GEN -- requirements
Module: car_cmd_gen

Interface
REQ-001 Parameter TURN_SEC, default 8, turn-signal auto-cancel time in clk_1Hz cycles; legal range 1..15.
REQ-002 Parameter FAULT_HOLD, default 3, cycles HAZARD persists after fault deasserts; legal range 1..15.
REQ-003 clk_1Hz  input  1  state clock, all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 drive_en  input  1  vehicle moving; level, synchronous to clk_1Hz.
REQ-006 turn_l  input  1  left lever request; level.
REQ-007 turn_r  input  1  right lever request; level.
REQ-008 hazard_btn  input  1  hazard push-button; a rising edge toggles the hazard latch.
REQ-009 fault  input  1  fault detected; level.
REQ-010 sw_code  output  4  registered command code consumed by the light/display controller.
REQ-011 timer  output  4  remaining seconds of the active turn or fault-hold countdown, else 0.
REQ-012 hazard_on  output  1  hazard latch state.

Function
REQ-013 States and codes SHALL be: OFF=0000, STRAIGHT=0110, LEFT=1000, RIGHT=0001, HAZARD=1111; sw_code SHALL equal the current-state code.
REQ-014 All inputs SHALL be sampled at the clk_1Hz rising edge; an input change SHALL be visible on sw_code at the next rising edge (1-cycle latency).
REQ-015 A hazard_btn rising edge SHALL be 0 on the previous sample and 1 on the current sample; each rising edge SHALL toggle hazard_on.
REQ-016 Priority per cycle, highest first: fault=1 -> HAZARD; hazard_on=1 (after this cycle's toggle) -> HAZARD; fault-hold count nonzero -> HAZARD; turn logic; base state.
REQ-017 Base state SHALL be STRAIGHT when drive_en=1, else OFF.
REQ-018 Falling edge of fault SHALL load the hold counter with FAULT_HOLD; the counter SHALL decrement once per cycle; HAZARD SHALL persist until it reaches 0; timer SHALL show the count.
REQ-019 fault reasserting during hold SHALL clear the hold counter; on the next falling edge the counter SHALL be reloaded.
REQ-020 A valid left request SHALL be turn_l=1, turn_r=0, left lock clear; a valid right request SHALL be the mirror case; turn_l=turn_r=1 SHALL count as no request.
REQ-021 Entering LEFT or RIGHT from any other state SHALL load the turn counter with TURN_SEC; a direct LEFT<->RIGHT switch SHALL reload it.
REQ-022 In LEFT/RIGHT the counter SHALL decrement each cycle while the request stays valid; the count reaching 0 SHALL return to the base state and set the lock for that direction.
REQ-023 A direction lock SHALL clear on the first cycle its lever samples 0.
REQ-024 A request dropping before timeout SHALL return to the base state next cycle without setting the lock.
REQ-025 Entering HAZARD SHALL clear the turn counter; on exit, turn logic SHALL restart from REQ-020 with a fresh TURN_SEC load.
REQ-026 turn requests SHALL be honoured whether drive_en is 0 or 1.
REQ-027 Counters SHALL saturate at 0 and never wrap.

Reset
REQ-028 On rst=0, asynchronously: state OFF, sw_code=0000, timer=0, hazard_on=0, both counters 0, both locks clear, hazard_btn previous sample 0.
REQ-029 Reset asserted mid-countdown or mid-hazard SHALL abort it; after release, a held hazard_btn=1 SHALL NOT count as an edge.

Structure
REQ-030 Shared package car_led_pkg SHALL hold the five 4-bit code constants and the state enumeration, also used by the downstream light controller.
REQ-031 Rising-edge detection SHALL be a sub-module rise_det (clk, rst, d, pulse), reused for hazard_btn.

Verification
REQ-032 Reset, drive_en=1, then idle 2 cycles -> sw_code 0000 during reset, 0110 after the first edge.
REQ-033 turn_l=1 held 12 cycles, TURN_SEC=8 -> sw_code 1000 for 8 cycles, timer 8..1, then 0110 while lock holds; turn_l 0 then 1 -> 1000 again.
REQ-034 In LEFT with timer=5, assert turn_r and drop turn_l -> next cycle 0001 with timer=8.
REQ-035 hazard_btn pulse while in RIGHT -> hazard_on=1 and sw_code 1111; second pulse -> 0110 or 0001 per levers, turn timer reloaded to 8.
REQ-036 fault 1 for 4 cycles then 0, FAULT_HOLD=3 -> 1111 for 4+3 cycles, timer 3,2,1, then base state; fault re-pulse at timer=2 -> 1111, hold restarts at 3.
REQ-037 turn_l=turn_r=1 with drive_en=0 -> sw_code stays 0000, timer 0.
